game_over_overlay: RTL

Parametrised game-over controller and text overlay for 1 to `N_PLAYERS` cars. It sits in the VGA chain after the sprite/track stages and does three things: freezes gameplay on timeout, resolves the winner sequentially, and draws a blinking "GAME OVER" / "PLAYER n WINS" / "DRAW" banner. It holds the screen for a minimum number of frames, then issues a restart pulse when start is pressed.

---
 rtl/game_over_pkg.sv | 55 +++++
 rtl/font_rom.sv | 53 +++++
 rtl/game_over_text_gen.sv | 62 ++++++
 rtl/game_over_overlay.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_over_pkg.sv
// Shared types and constants for the game-over controller and banner overlay.
// Holds the FSM state enum, the VGA bus layout, the banner character codes
// (ASCII, with a dedicated blank code) and a winner-to-digit helper.
package game_over_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StResolve,
    StShow,
    StRestart
  } state_e;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 11;
  localparam int unsigned RGB_W  = 12;

  typedef struct packed {
    logic [VCNT_W-1:0] vcount;
    logic              vsync;
    logic              vblnk;
    logic [HCNT_W-1:0] hcount;
    logic              hsync;
    logic              hblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;

  localparam int unsigned VGA_BUS_SIZE = $bits(vga_bus_t);

  localparam logic [6:0] CharA     = 7'h41;
  localparam logic [6:0] CharD     = 7'h44;
  localparam logic [6:0] CharE     = 7'h45;
  localparam logic [6:0] CharG     = 7'h47;
  localparam logic [6:0] CharI     = 7'h49;
  localparam logic [6:0] CharL     = 7'h4c;
  localparam logic [6:0] CharM     = 7'h4d;
  localparam logic [6:0] CharN     = 7'h4e;
  localparam logic [6:0] CharO     = 7'h4f;
  localparam logic [6:0] CharP     = 7'h50;
  localparam logic [6:0] CharR     = 7'h52;
  localparam logic [6:0] CharS     = 7'h53;
  localparam logic [6:0] CharV     = 7'h56;
  localparam logic [6:0] CharW     = 7'h57;
  localparam logic [6:0] CharY     = 7'h59;
  localparam logic [6:0] CharOne   = 7'h31;
  localparam logic [6:0] CharTwo   = 7'h32;
  localparam logic [6:0] CharThree = 7'h33;
  localparam logic [6:0] CharFour  = 7'h34;
  localparam logic [6:0] CharSpace = 7'h7f;

  // Players are shown 1-based on screen.
  function automatic logic [6:0] winner_digit(input logic [1:0] idx);
    return CharOne + {5'd0, idx};
  endfunction

endpackage

// File: rtl/font_rom.sv
// Combinational 8x16 glyph ROM for the banner character set.
// addr_i : {char_code[6:0], font_line[3:0]}
// data_o : 8 pixels of that line, MSB is the leftmost pixel.
// Glyphs occupy lines 4..11; all other lines and unknown codes are blank.
module font_rom
  import game_over_pkg::*;
(
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  logic [6:0]      code;
  logic [3:0]      line;
  logic [7:0][7:0] glyph;
  logic [2:0]      row;
  logic            in_glyph;

  assign code = addr_i[10:4];
  assign line = addr_i[3:0];
  // Lines 4..7 map to rows 0..3, lines 8..11 to rows 4..7.
  assign in_glyph = line[3] ^ line[2];
  assign row      = {line[3], line[1:0]};

  always_comb begin
    glyph = '0;
    case (code)
      CharA:     glyph = 64'h183c66667e666666;
      CharD:     glyph = 64'hf8ccc6c6c6c6ccf8;
      CharE:     glyph = 64'hfec0c0fcc0c0c0fe;
      CharG:     glyph = 64'h3c66c0c0cec6663e;
      CharI:     glyph = 64'h7e1818181818187e;
      CharL:     glyph = 64'hc0c0c0c0c0c0c0fe;
      CharM:     glyph = 64'hc6eefed6c6c6c6c6;
      CharN:     glyph = 64'hc6e6f6decec6c6c6;
      CharO:     glyph = 64'h7cc6c6c6c6c6c67c;
      CharP:     glyph = 64'hfcc6c6fcc0c0c0c0;
      CharR:     glyph = 64'hfcc6c6fcd8ccc6c6;
      CharS:     glyph = 64'h7cc6c07c0606c67c;
      CharV:     glyph = 64'hc6c6c6c6c66c3810;
      CharW:     glyph = 64'hc6c6c6d6feeec682;
      CharY:     glyph = 64'hc6c66c3818181818;
      CharOne:   glyph = 64'h183818181818187e;
      CharTwo:   glyph = 64'h7cc6060c3060c0fe;
      CharThree: glyph = 64'h7cc6063c0606c67c;
      CharFour:  glyph = 64'h0c1c3c6cccfe0c0c;
      default:   glyph = '0;
    endcase
  end

  // glyph[7] is the top row.
  assign data_o = in_glyph ? glyph[3'd7 - row] : 8'h00;

endmodule

// File: rtl/game_over_text_gen.sv
// Banner text lookup: maps a text cell to a character code.
// valid_i  : cell lies inside the banner area
// row_i    : 0 = "GAME OVER", 1 = "PLAYER n WINS" or "DRAW"
// col_i    : character column within the row
// winner_i : winning player index, draw_i selects the tie text
// char_o   : character code, blank code for unused cells
module game_over_text_gen
  import game_over_pkg::*;
#(
  parameter int unsigned WinW = 1
) (
  input  logic            valid_i,
  input  logic            row_i,
  input  logic [3:0]      col_i,
  input  logic [WinW-1:0] winner_i,
  input  logic            draw_i,
  output logic [6:0]      char_o
);

  always_comb begin
    char_o = CharSpace;
    if (valid_i) begin
      if (!row_i) begin
        case (col_i)
          4'd0:    char_o = CharG;
          4'd1:    char_o = CharA;
          4'd2:    char_o = CharM;
          4'd3:    char_o = CharE;
          4'd5:    char_o = CharO;
          4'd6:    char_o = CharV;
          4'd7:    char_o = CharE;
          4'd8:    char_o = CharR;
          default: char_o = CharSpace;
        endcase
      end else if (draw_i) begin
        case (col_i)
          4'd0:    char_o = CharD;
          4'd1:    char_o = CharR;
          4'd2:    char_o = CharA;
          4'd3:    char_o = CharW;
          default: char_o = CharSpace;
        endcase
      end else begin
        case (col_i)
          4'd0:    char_o = CharP;
          4'd1:    char_o = CharL;
          4'd2:    char_o = CharA;
          4'd3:    char_o = CharY;
          4'd4:    char_o = CharE;
          4'd5:    char_o = CharR;
          4'd7:    char_o = winner_digit(2'(winner_i));
          4'd9:    char_o = CharW;
          4'd10:   char_o = CharI;
          4'd11:   char_o = CharN;
          4'd12:   char_o = CharS;
          default: char_o = CharSpace;
        endcase
      end
    end
  end

endmodule

// File: rtl/game_over_overlay.sv
// Game-over controller and banner overlay.
// Freezes play on time_out, resolves the winner one player per cycle, then
// shows a blinking banner until start_btn is pressed after the hold time.
// pclk/rst          : pixel clock, synchronous active-high reset
// time_out          : race timer expired (level)
// no_of_players     : active players, sampled when leaving PLAY
// player_scores     : packed scores, player 0 in the LSBs
// start_btn         : debounced start level
// vga_in / vga_out  : VGA bus in, bus out delayed 2 cycles with overlay
// gremlins_enable   : gremlin sprites active
// car_enable        : per-car enable
// winner / draw     : result, winner valid when draw is 0
// restart           : one-cycle restart pulse
module game_over_overlay
  import game_over_pkg::*;
#(
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned TEXT_X0      = 64,
  parameter int unsigned TEXT_Y0      = 128,
  parameter int unsigned SCALE_LOG2   = 3,
  parameter logic [11:0] FG_RGB       = 12'hfff,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic                            pclk,
  input  logic                            rst,
  input  logic                            time_out,
  input  logic [$clog2(N_PLAYERS+1)-1:0]  no_of_players,
  input  logic [N_PLAYERS*SCORE_W-1:0]    player_scores,
  input  logic                            start_btn,
  input  logic [VGA_BUS_SIZE-1:0]         vga_in,
  output logic [VGA_BUS_SIZE-1:0]         vga_out,
  output logic                            gremlins_enable,
  output logic [N_PLAYERS-1:0]            car_enable,
  output logic [$clog2(N_PLAYERS)-1:0]    winner,
  output logic                            draw,
  output logic                            restart
);

  localparam int unsigned PW     = $clog2(N_PLAYERS + 1);
  localparam int unsigned WW     = $clog2(N_PLAYERS);
  localparam int unsigned HoldW  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  vga_bus_t vin;
  assign vin = vga_in;

  // Control state.
  state_e             state_q, state_d;
  logic               time_out_q;
  logic               armed_q, armed_d;
  logic               start_prev_q;
  logic               vblnk_prev_q;
  logic [PW-1:0]      nplayers_q, nplayers_d;
  logic [SCORE_W-1:0] scores_q [N_PLAYERS];
  logic [SCORE_W-1:0] scores_d [N_PLAYERS];
  logic [WW-1:0]      idx_q, idx_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [WW-1:0]      best_idx_q, best_idx_d;
  logic               tie_q, tie_d;
  logic [WW-1:0]      winner_q, winner_d;
  logic               draw_q, draw_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  logic               frame_tick;
  logic               start_rise;
  logic [SCORE_W-1:0] cur_score;
  logic               last_player;

  assign frame_tick  = vin.vblnk & ~vblnk_prev_q;
  assign start_rise  = start_btn & ~start_prev_q;
  assign cur_score   = scores_q[idx_q];
  // Also stop at the top index so an out-of-range player count cannot wrap.
  assign last_player = (PW'(idx_q) + PW'(1) >= nplayers_q) ||
                       (idx_q == WW'(N_PLAYERS - 1));

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    nplayers_d  = nplayers_q;
    scores_d    = scores_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    tie_d       = tie_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    // time_out must be seen low before it may trigger again after a restart.
    if (!time_out_q) armed_d = 1'b1;

    unique case (state_q)
      StPlay: begin
        if (time_out_q && armed_q) begin
          state_d    = StResolve;
          nplayers_d = no_of_players;
          idx_d      = '0;
          for (int i = 0; i < int'(N_PLAYERS); i++) begin
            scores_d[i] = player_scores[i*SCORE_W +: SCORE_W];
          end
        end
      end
      StResolve: begin
        // Player 0 seeds the comparator so a zero score is not seen as a tie.
        if (idx_q == '0) begin
          best_d     = cur_score;
          best_idx_d = '0;
          tie_d      = 1'b0;
        end else if (cur_score > best_q) begin
          best_d     = cur_score;
          best_idx_d = idx_q;
          tie_d      = 1'b0;
        end else if (cur_score == best_q) begin
          tie_d = 1'b1;
        end
        if (last_player) begin
          state_d     = StShow;
          winner_d    = best_idx_d;
          draw_d      = tie_d;
          hold_d      = '0;
          blink_cnt_d = '0;
          blink_d     = 1'b0;
        end else begin
          idx_d = idx_q + WW'(1);
        end
      end
      StShow: begin
        if (frame_tick) begin
          if (hold_q < HoldW'(HOLD_FRAMES)) hold_d = hold_q + HoldW'(1);
          if (blink_cnt_q >= BlinkW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
        end
        if ((hold_q >= HoldW'(HOLD_FRAMES)) && start_rise) state_d = StRestart;
      end
      StRestart: begin
        state_d = StPlay;
        armed_d = 1'b0;
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= StPlay;
      time_out_q   <= 1'b0;
      armed_q      <= 1'b1;
      start_prev_q <= 1'b0;
      vblnk_prev_q <= 1'b0;
      nplayers_q   <= '0;
      for (int i = 0; i < int'(N_PLAYERS); i++) scores_q[i] <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      tie_q        <= 1'b0;
      winner_q     <= '0;
      draw_q       <= 1'b0;
      hold_q       <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_out_q   <= time_out;
      armed_q      <= armed_d;
      start_prev_q <= start_btn;
      vblnk_prev_q <= vin.vblnk;
      nplayers_q   <= nplayers_d;
      scores_q     <= scores_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      tie_q        <= tie_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
      hold_q       <= hold_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
    end
  end

  // Status outputs.
  always_comb begin
    gremlins_enable = 1'b0;
    car_enable      = '0;
    unique case (state_q)
      StPlay: begin
        gremlins_enable = 1'b1;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
          car_enable[i] = (i < int'(no_of_players));
        end
      end
      StShow: begin
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
          car_enable[i] = !draw_q && (int'(winner_q) == i);
        end
      end
      default: ;
    endcase
  end

  assign winner  = winner_q;
  assign draw    = draw_q;
  assign restart = (state_q == StRestart);

  // Overlay pipeline: stage 1 registers the cell lookup, stage 2 the font pixel.
  logic [HCNT_W-1:0] h_off, col_full;
  logic [VCNT_W-1:0] v_off, row_full;
  logic              in_banner;
  logic [6:0]        code_d, code_q;
  logic [3:0]        line_d, line_q;
  logic [2:0]        bitsel_d, bitsel_q;
  logic              ov_en_d, ov_en_q;
  vga_bus_t          vga_d1_q, vga_d2_q;
  logic [7:0]        rom_data;
  logic              pix_d, pix_q;

  always_comb begin
    h_off     = vin.hcount - HCNT_W'(TEXT_X0);
    v_off     = vin.vcount - VCNT_W'(TEXT_Y0);
    col_full  = h_off >> (3 + SCALE_LOG2);
    row_full  = v_off >> (4 + SCALE_LOG2);
    in_banner = (vin.hcount >= HCNT_W'(TEXT_X0)) && (vin.vcount >= VCNT_W'(TEXT_Y0)) &&
                (col_full < HCNT_W'(16)) && (row_full < VCNT_W'(2));
    line_d    = v_off[SCALE_LOG2+3 -: 4];
    bitsel_d  = h_off[SCALE_LOG2+2 -: 3];
    ov_en_d   = (state_q == StShow) && !blink_q && in_banner;
  end

  game_over_text_gen #(
    .WinW (WW)
  ) u_text_gen (
    .valid_i  (in_banner),
    .row_i    (row_full[0]),
    .col_i    (col_full[3:0]),
    .winner_i (winner_q),
    .draw_i   (draw_q),
    .char_o   (code_d)
  );

  font_rom u_font_rom (
    .addr_i (({code_q, line_q})),
    .data_o (rom_data)
  );

  assign pix_d = ov_en_q && (code_q != CharSpace) && rom_data[3'd7 - bitsel_q];

  always_ff @(posedge pclk) begin
    if (rst) begin
      code_q   <= CharSpace;
      line_q   <= '0;
      bitsel_q <= '0;
      ov_en_q  <= 1'b0;
      vga_d1_q <= '0;
      vga_d2_q <= '0;
      pix_q    <= 1'b0;
    end else begin
      code_q   <= code_d;
      line_q   <= line_d;
      bitsel_q <= bitsel_d;
      ov_en_q  <= ov_en_d;
      vga_d1_q <= vin;
      vga_d2_q <= vga_d1_q;
      pix_q    <= pix_d;
    end
  end

  always_comb begin
    vga_bus_t vout;
    vout = vga_d2_q;
    if (pix_q && !vga_d2_q.hblnk && !vga_d2_q.vblnk) vout.rgb = FG_RGB;
    vga_out = vout;
  end

endmodule
